// File: rtl/fft_cu_pkg.sv
// Shared types, defaults and helpers for the parametrised FFT stage control unit.
package fft_cu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} cu_state_t;

  localparam int DEF_N_POINTS = 512;
  localparam int MAX_ADDR_W   = 12;
  localparam int MAX_DLY      = 8;

  // Twiddle index: sample address scaled by the stage stride, wrapped to the frame size.
  function automatic logic [MAX_ADDR_W-1:0] tw_index(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int stage,
                                                     input int addr_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << addr_w) - MAX_ADDR_W'(1);
    return (addr << stage) & mask;
  endfunction

endpackage

// File: rtl/cu_stage_if.sv
// Alert-chain and datapath-control bundle between a stage control unit and its neighbours.
interface cu_stage_if
  import fft_cu_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEF_N_POINTS)
);
  logic              alert_in;
  logic              clr;
  logic              bf_en;
  logic              mul_en;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] tw_addr;
  logic              alert_out;
  logic              frame_done;
  logic              busy;
  logic [7:0]        frame_cnt;

  modport master (
    output alert_in, clr,
    input  bf_en, mul_en, addr, tw_addr, alert_out, frame_done, busy, frame_cnt
  );

  modport slave (
    input  alert_in, clr,
    output bf_en, mul_en, addr, tw_addr, alert_out, frame_done, busy, frame_cnt
  );
endinterface

// File: rtl/cu_dly_line.sv
// Clearable single-bit delay line; empty flags that no enable is still in flight.
module cu_dly_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic d,
  output logic q,
  output logic empty
);
  logic [DEPTH-1:0] sr;

  // NOTE: non-blocking assignment so every stage shifts from the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    sr <= '0;
    else if (clr) sr <= '0;
    else          sr <= (sr << 1) | DEPTH'(d);
  end

  assign q     = sr[DEPTH-1];
  assign empty = ~|sr;
endmodule

// File: rtl/cu_stage.sv
// FFT stage control unit: turns upstream alerts into butterfly/multiplier enables and addresses.
module cu_stage
  import fft_cu_pkg::*;
#(
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int ADDR_W   = $clog2(N_POINTS),
  parameter int STAGE    = 1,
  parameter int MUL_DLY  = 1,
  parameter int OUT_DLY  = 1
) (
  input logic        clk,
  input logic        rstn,
  cu_stage_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POINTS - 1);

  cu_state_t             state;
  logic                  bf_en;
  logic [ADDR_W-1:0]     addr;
  logic                  frame_done;
  logic                  busy;
  logic [7:0]            frame_cnt;
  logic                  mul_empty;
  logic                  out_empty;
  logic                  last_sample;
  logic [MAX_ADDR_W-1:0] tw_full;

  assign last_sample = bf_en && (addr == LAST);

  // clr wins over alert_in and suppresses the frame_done of a frame it cuts short.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bf_en      <= 1'b0;
      addr       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (bus.clr) begin
        bf_en <= 1'b0;
        addr  <= '0;
      end else begin
        bf_en <= bus.alert_in;
        if (bf_en) addr <= addr + ADDR_W'(1);
        if (last_sample) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // busy is updated with the state so it tracks the registered state without extra lag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (bus.clr) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (bf_en) begin
                 state <= RUN;
                 busy  <= 1'b1;
               end
        RUN:   if (last_sample) state <= DRAIN;
        DRAIN: if (bf_en) state <= RUN;
               else if (mul_empty && out_empty) begin
                 state <= IDLE;
                 busy  <= 1'b0;
               end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  cu_dly_line #(.DEPTH(MUL_DLY)) u_mul_dly (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (bus.clr),
    .d     (bf_en),
    .q     (bus.mul_en),
    .empty (mul_empty)
  );

  cu_dly_line #(.DEPTH(OUT_DLY)) u_out_dly (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (bus.clr),
    .d     (bf_en),
    .q     (bus.alert_out),
    .empty (out_empty)
  );

  assign tw_full        = tw_index(MAX_ADDR_W'(addr), STAGE, ADDR_W);
  assign bus.tw_addr    = tw_full[ADDR_W-1:0];
  assign bus.bf_en      = bf_en;
  assign bus.addr       = addr;
  assign bus.frame_done = frame_done;
  assign bus.busy       = busy;
  assign bus.frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_cu_stage.sv
// Directed bench for cu_stage (16 points, stage 2, multiplier delay 3, output delay 1).
module tb_cu_stage;
  import fft_cu_pkg::*;

  localparam int N   = 16;
  localparam int AW  = 4;
  localparam int STG = 2;
  localparam int MD  = 3;
  localparam int OD  = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  cu_stage_if #(.ADDR_W(AW)) bus ();

  cu_stage #(
    .N_POINTS (N),
    .STAGE    (STG),
    .MUL_DLY  (MD),
    .OUT_DLY  (OD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [AW-1:0] addr_q[$];
  logic [7:0]  hist;
  int          samples;
  logic        fd_pend;
  logic [7:0]  cnt;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist    = '0;
    samples = 0;
    fd_pend = 1'b0;
    cnt     = '0;
    addr_q.delete();
  endtask

  // One clock: drive inputs, predict from the alert/clr history, compare just after the edge.
  task automatic step(input logic a, input logic c);
    logic          fire;
    logic          exp_fd;
    logic [AW-1:0] e;
    bus.alert_in = a;
    bus.clr      = c;
    @(posedge clk);
    #1;
    fire = a && !c;
    if (c) begin
      hist    = '0;
      samples = 0;
      fd_pend = 1'b0;
      addr_q.delete();
    end
    exp_fd  = fd_pend;
    if (fd_pend) cnt = cnt + 8'd1;
    fd_pend = 1'b0;
    hist    = {hist[6:0], fire};
    if (fire) begin
      addr_q.push_back(AW'(samples));
      samples++;
      if (samples == N) begin
        samples = 0;
        fd_pend = 1'b1;
      end
    end
    check1("bf_en", bus.bf_en, fire);
    if (bus.bf_en === 1'b1) begin
      check1("sb_depth", (addr_q.size() > 0), 1);
      if (addr_q.size() > 0) begin
        e = addr_q.pop_front();
        check1("addr", bus.addr, e);
        check1("tw_addr", bus.tw_addr, (int'(e) * (1 << STG)) % N);
      end
    end
    check1("mul_en", bus.mul_en, hist[MD]);
    check1("alert_out", bus.alert_out, hist[OD]);
    check1("frame_done", bus.frame_done, exp_fd);
    check1("frame_cnt", bus.frame_cnt, cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_bf_en"}, bus.bf_en, 0);
    check1({tag, "_mul_en"}, bus.mul_en, 0);
    check1({tag, "_addr"}, bus.addr, 0);
    check1({tag, "_tw_addr"}, bus.tw_addr, 0);
    check1({tag, "_alert_out"}, bus.alert_out, 0);
    check1({tag, "_frame_done"}, bus.frame_done, 0);
    check1({tag, "_busy"}, bus.busy, 0);
    check1({tag, "_frame_cnt"}, bus.frame_cnt, 0);
  endtask

  initial begin
    bus.alert_in = 1'b1;
    bus.clr      = 1'b0;
    model_reset();

    // Reset held with alert_in high: everything stays at zero.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // Single full frame, then drain.
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b0);
      if (i == 0) check1("busy_first", bus.busy, 0);
      if (i == 1) check1("busy_rise", bus.busy, 1);
    end
    repeat (8) step(1'b0, 1'b0);
    check1("busy_drained1", bus.busy, 0);

    // Gapped alerts, pattern 1101: 21 cycles carry exactly 16 samples.
    for (int i = 0; i < 21; i++) step((i % 4) != 2, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check1("busy_drained2", bus.busy, 0);

    // Three back-to-back frames.
    for (int i = 0; i < 3 * N; i++) begin
      step(1'b1, 1'b0);
      if (i > 0) check1("busy_b2b", bus.busy, 1);
    end
    repeat (8) step(1'b0, 1'b0);
    check1("busy_drained3", bus.busy, 0);

    // Abort at addr 7 with alert_in still high.
    repeat (8) step(1'b1, 1'b0);
    check1("pre_clr_addr", bus.addr, 7);
    step(1'b1, 1'b1);
    check1("clr_addr", bus.addr, 0);
    check1("clr_busy", bus.busy, 0);
    repeat (N) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    repeat (5) step(1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    bus.alert_in = 1'b0;
    #1;
    rstn = 1'b1;
    model_reset();
    repeat (2) step(1'b0, 1'b0);

    // 256 continuous frames: the counter passes 255 and wraps to 0.
    repeat (256 * N) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check1("wrap_done", bus.frame_done, 1);
    check1("wrap_cnt", bus.frame_cnt, 0);
    repeat (8) step(1'b0, 1'b0);
    check1("busy_final", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cu_stage.md
# cu_stage

Parametrised control unit for one FFT pipeline stage. It generalises the fixed per-stage controllers: a single module serves every stage, selected by parameters. It converts the upstream stage's per-sample `alert_in` into butterfly/multiplier enables and an in-frame sample address (addr generation is built in). It also produces a stage-dependent twiddle address, configurable enable latencies, frame-completion signalling and a synchronous abort. It sits between stage k-1 and stage k+1 in the alert chain, driving the butterfly and twiddle-multiplier datapaths of stage k.

## Interface
- `N_POINTS`, 512: FFT size; power of two, 4..4096.
- `ADDR_W`, `$clog2(N_POINTS)`: address width; derived, not overridden.
- `STAGE`, 1: stage index, 0..ADDR_W-1; sets twiddle stride.
- `MUL_DLY`, 1: cycles from `bf_en` to `mul_en`, 1..8.
- `OUT_DLY`, 1: cycles from `bf_en` to `alert_out`, 1..8.
- `clk` in 1: single clock, all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `alert_in` in 1: upstream per-sample valid (level, may gap mid-frame).
- `clr` in 1: synchronous abort of current frame, active-high.
- `bf_en` out 1: butterfly enable.
- `mul_en` out 1: twiddle multiplier enable.
- `addr` out ADDR_W: in-frame sample index, valid while `bf_en`=1.
- `tw_addr` out ADDR_W: twiddle ROM index, valid while `bf_en`=1.
- `alert_out` out 1: valid to next stage's `alert_in`.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `busy` out 1: high when FSM is not IDLE.
- `frame_cnt` out 8: completed-frame counter, wraps 255->0.

## Operation
- All outputs reset to 0; FSM resets to IDLE; delay lines clear.
- `bf_en` is `alert_in` registered once.
- `mul_en` is `bf_en` through a MUL_DLY-deep shift register. `alert_out` is `bf_en` through an OUT_DLY-deep shift register.
- `addr` counts `bf_en` cycles within a frame. It advances by 1 after each `bf_en`=1 cycle and holds during gaps. It wraps N_POINTS-1 -> 0.
- `tw_addr` = (`addr` << STAGE) mod N_POINTS, combinational from the `addr` register.
- FSM states:
  - IDLE -> RUN on `bf_en`=1.
  - RUN -> DRAIN on `bf_en`=1 with `addr`=N_POINTS-1.
  - DRAIN -> RUN if `bf_en`=1. This is a back-to-back frame and takes priority.
  - DRAIN -> IDLE once `bf_en`=0 and both delay lines are all-zero.
- `frame_done` pulses and `frame_cnt` increments on the cycle after the `bf_en` cycle carrying `addr`=N_POINTS-1.
- `clr`=1 has the following effect:
  - Next cycle: `bf_en`, both delay lines, `addr` = 0; FSM -> IDLE.
  - `frame_cnt` is preserved.
  - No `frame_done` is generated.
  - `alert_in` sampled in the same cycle is dropped (`clr` has priority).
- `alert_in` held high continuously yields back-to-back frames with no bubble.

## Timing
- `alert_in` high at edge t -> `bf_en` high t+1 -> `mul_en` high t+1+MUL_DLY -> `alert_out` high t+1+OUT_DLY.
- `addr` and `tw_addr` are registered and valid in the same cycle as the `bf_en` they belong to.
- First sample of a frame: `addr`=0, `tw_addr`=0.
- `frame_done` latency: 1 cycle after the last `bf_en` of the frame. `frame_cnt` shows the new value in that same cycle.
- `busy` rises the cycle after the first `bf_en` of a frame (IDLE->RUN registered). It falls the cycle after the last `alert_out`/`mul_en` bit drains.
- Asynchronous reset mid-frame: all outputs 0 immediately. The next frame restarts at `addr`=0.

## Structure
- Shared package `fft_cu_pkg` contains:
  - enum `cu_state_t` {IDLE, RUN, DRAIN};
  - localparam defaults for N_POINTS and delay maxima;
  - function `tw_index(addr, stage, addr_w)`.
- One sub-module, `cu_dly_line` (parameter DEPTH; ports clk, rstn, clr, d, q, `empty`), is instantiated twice for the `mul_en` and `alert_out` paths.
- The address counter and FSM live in `cu_stage` itself.

## Test plan
- Reset: hold `rstn`=0 with `alert_in`=1 -> every output 0. Release -> first `bf_en` one cycle after the next sampled `alert_in`.
- N_POINTS=16, STAGE=2, MUL_DLY=3, OUT_DLY=1, `alert_in` high 16 cycles:
  - `addr` 0..15, `tw_addr` 0,4,8,12,0,4,...;
  - `mul_en` lags `bf_en` by 3, `alert_out` lags `bf_en` by 1;
  - one `frame_done`, `frame_cnt`=1, `busy` low once drained.
- N_POINTS=16, `alert_in` with gaps (pattern 1101 repeated) -> `addr` holds across gaps, reaches 15 after 16 valid samples, exactly one `frame_done`.
- `alert_in` high 48 cycles continuously -> three `frame_done` pulses 16 cycles apart, no bubble in `bf_en`, FSM never returns to IDLE until drain.
- `clr` asserted at `addr`=7 with `alert_in`=1 -> next cycle `bf_en`=0 and `addr`=0; `frame_cnt` unchanged; no `frame_done`. Next frame starts at `addr`=0.
- Preload `frame_cnt`=255 by running 255 frames, then complete one more -> `frame_cnt` wraps to 0 with a normal `frame_done` pulse.
